// File: rtl/cic_integrator_decim.sv
// cic_integrator_decim: N-stage wrapping integrator cascade with decimate-by-R output strobe.
module cic_integrator_decim #(
  parameter int IW = 2,
  parameter int OW = 16,
  parameter int N  = 5,
  parameter int R  = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ready,
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_data,
  output logic          o_ready
);
  localparam int CW = $clog2(R);
  logic [OW-1:0] acc_q [N];
  logic [OW-1:0] acc_d [N];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] o_data_q, o_data_d;
  logic          o_ready_q, o_ready_d;
  logic          last;
  assign last = i_ready && (cnt_q == CW'(R - 1));
  // every stage adds the pre-update value of its predecessor, so the cascade is pipelined
  always_comb begin
    acc_d = acc_q;
    if (i_ready) begin
      acc_d[0] = acc_q[0] + {{(OW-IW){i_data[IW-1]}}, i_data};
      for (int k = 1; k < N; k++) acc_d[k] = acc_q[k] + acc_q[k-1];
    end
    cnt_d     = !i_ready ? cnt_q : last ? '0 : cnt_q + CW'(1);
    o_data_d  = last ? acc_d[N-1] : o_data_q;
    o_ready_d = last;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
      cnt_q     <= '0;
      o_data_q  <= '0;
      o_ready_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_ready_q <= o_ready_d;
    end
  end
  assign o_data  = o_data_q;
  assign o_ready = o_ready_q;
endmodule

// File: tb/tb_cic_integrator_decim.sv
// tb_cic_integrator_decim: four parameterisations driven in lockstep against hand-computed vectors.
module tb_cic_integrator_decim;
  logic i_clk = 1'b0;
  logic i_rst_n, i_ready;
  logic [1:0] d1, d3, dw, dn;
  logic [15:0] o1, o3, on;
  logic [3:0] ow;
  logic r1, r3, rw, rn;
  int checks = 0;
  int errors = 0;
  always #5 i_clk = ~i_clk;
  cic_integrator_decim #(.IW(2), .OW(16), .N(1), .R(4)) u1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ready(i_ready), .i_data(d1), .o_data(o1), .o_ready(r1));
  cic_integrator_decim #(.IW(2), .OW(16), .N(3), .R(4)) u3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ready(i_ready), .i_data(d3), .o_data(o3), .o_ready(r3));
  cic_integrator_decim #(.IW(2), .OW(4), .N(1), .R(2)) uw (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ready(i_ready), .i_data(dw), .o_data(ow), .o_ready(rw));
  cic_integrator_decim #(.IW(2), .OW(16), .N(2), .R(2)) un (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ready(i_ready), .i_data(dn), .o_data(on), .o_ready(rn));
  typedef struct {
    logic d3;
    logic r4;
    logic r2;
    int   e1;
    int   e3;
    int   ew;
    int   en;
  } vec_t;
  vec_t tab [16];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int rr4, input int rr2,
                         input int e1, input int e3, input int ew_e, input int en_e);
    chk({tag, " u1.o_ready"}, int'(r1), rr4);
    chk({tag, " u3.o_ready"}, int'(r3), rr4);
    chk({tag, " uw.o_ready"}, int'(rw), rr2);
    chk({tag, " un.o_ready"}, int'(rn), rr2);
    chk({tag, " u1.o_data"}, int'($signed(o1)), e1);
    chk({tag, " u3.o_data"}, int'($signed(o3)), e3);
    chk({tag, " uw.o_data"}, int'($signed(ow)), ew_e);
    chk({tag, " un.o_data"}, int'($signed(on)), en_e);
  endtask
  initial begin
    int v, x;
    logic g;
    tab[0]  = '{1'b1, 1'b0, 1'b0,  0,   0,  0,    0};
    tab[1]  = '{1'b0, 1'b0, 1'b1,  0,   0,  2,   -2};
    tab[2]  = '{1'b0, 1'b0, 1'b0,  0,   0,  2,   -2};
    tab[3]  = '{1'b0, 1'b1, 1'b1,  4,   3,  4,  -12};
    tab[4]  = '{1'b0, 1'b0, 1'b0,  4,   3,  4,  -12};
    tab[5]  = '{1'b0, 1'b0, 1'b1,  4,   3,  6,  -30};
    tab[6]  = '{1'b0, 1'b0, 1'b0,  4,   3,  6,  -30};
    tab[7]  = '{1'b0, 1'b1, 1'b1,  8,  21, -8,  -56};
    tab[8]  = '{1'b0, 1'b0, 1'b0,  8,  21, -8,  -56};
    tab[9]  = '{1'b0, 1'b0, 1'b1,  8,  21, -6,  -90};
    tab[10] = '{1'b0, 1'b0, 1'b0,  8,  21, -6,  -90};
    tab[11] = '{1'b0, 1'b1, 1'b1, 12,  55, -4, -132};
    tab[12] = '{1'b0, 1'b0, 1'b0, 12,  55, -4, -132};
    tab[13] = '{1'b0, 1'b0, 1'b1, 12,  55, -2, -182};
    tab[14] = '{1'b0, 1'b0, 1'b0, 12,  55, -2, -182};
    tab[15] = '{1'b0, 1'b1, 1'b1, 16, 105,  0, -240};
    i_rst_n = 1'b0;
    i_ready = 1'b0;
    d1 = 2'b00; d3 = 2'b00; dw = 2'b00; dn = 2'b00;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    d1 = 2'b01; dw = 2'b01; dn = 2'b10;
    for (int i = 0; i < 16; i++) begin
      d3 = {1'b0, tab[i].d3};
      @(negedge i_clk);
      chk_all($sformatf("vec%0d", i), int'(tab[i].r4), int'(tab[i].r2),
              tab[i].e1, tab[i].e3, tab[i].ew, tab[i].en);
    end
    i_ready = 1'b0;
    d1 = 2'b10; dw = 2'b10; dn = 2'b01;
    @(negedge i_clk);
    chk_all("idle", 0, 0, 16, 105, 0, -240);
    i_ready = 1'b1;
    d1 = 2'b01; dw = 2'b01; dn = 2'b10; d3 = 2'b00;
    repeat (6) @(negedge i_clk);
    chk("pre_rst uw.o_ready", int'(rw), 1);
    chk("pre_rst u1.o_ready", int'(r1), 0);
    chk("pre_rst u1.o_data", int'($signed(o1)), 20);
    i_rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    chk_all("rst_held", 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      g = (c % 3 == 0);
      i_ready = g;
      d1 = g ? 2'b01 : 2'b10;
      dw = g ? 2'b01 : 2'b11;
      @(negedge i_clk);
      v = c / 3 + 1;
      x = (2 * (v / 2)) % 16;
      x = (x >= 8) ? x - 16 : x;
      chk($sformatf("gap%0d u1.o_ready", c), int'(r1), int'(g && (v % 4 == 0)));
      chk($sformatf("gap%0d u1.o_data", c), int'($signed(o1)), 4 * (v / 4));
      chk($sformatf("gap%0d uw.o_ready", c), int'(rw), int'(g && (v % 2 == 0)));
      chk($sformatf("gap%0d uw.o_data", c), int'($signed(ow)), x);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
